// File: rtl/alu_mdu.sv
// EX-stage ALU with iterative multiply/divide unit and architectural HI/LO registers.
// Optional feature macro: ALU_DIV_EN compiles in the DIV/DIVU datapath and divide-by-zero handling.
module alu_mdu #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [4:0]       ALUOp,
  input  logic             start,
  output logic [WIDTH-1:0] C,
  output logic             zero,
  output logic             overflow,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam int unsigned W2   = 2 * WIDTH;
  localparam int unsigned WX   = WIDTH + 1;
  localparam int unsigned HALF = WIDTH / 2;

  localparam logic [4:0] OP_ADDU  = 5'b00001;
  localparam logic [4:0] OP_SUBU  = 5'b00010;
  localparam logic [4:0] OP_OR    = 5'b00011;
  localparam logic [4:0] OP_EQL   = 5'b00100;
  localparam logic [4:0] OP_LUI   = 5'b00101;
  localparam logic [4:0] OP_ADD   = 5'b00110;
  localparam logic [4:0] OP_SUB   = 5'b00111;
  localparam logic [4:0] OP_AND   = 5'b01000;
  localparam logic [4:0] OP_SLT   = 5'b01001;
  localparam logic [4:0] OP_SLTU  = 5'b01010;
  localparam logic [4:0] OP_MULT  = 5'b10000;
  localparam logic [4:0] OP_MULTU = 5'b10001;
  localparam logic [4:0] OP_DIV   = 5'b10010;
  localparam logic [4:0] OP_DIVU  = 5'b10011;
  localparam logic [4:0] OP_MFHI  = 5'b10100;
  localparam logic [4:0] OP_MFLO  = 5'b10101;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_MUL  = 3'd1,
    S_DIV  = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic             busy_d, done_d;
  logic [W2-1:0]    acc_q;
  logic [WIDTH-1:0] opnd_q;
  logic             neg_lo_q;
  logic [CNT_W-1:0] cnt_q;

  logic             signed_op, a_neg, b_neg, mul_req, div_req;
  logic [WIDTH-1:0] mag_a, mag_b, sum, diff;
  logic [WX-1:0]    mul_sum;
  logic [W2-1:0]    mul_next, prod;
  logic [WIDTH-1:0] fix_hi, fix_lo;

`ifdef ALU_DIV_EN
  logic             op_div_q, div0_q, neg_hi_q;
  logic [WIDTH-1:0] a_raw_q;
  logic [WX-1:0]    div_diff;
  logic [W2-1:0]    div_next;
`endif

  assign sum  = A + B;
  assign diff = A - B;

  // Single-cycle result, flags and HI/LO moves
  always_comb begin
    C        = '0;
    overflow = 1'b0;
    case (ALUOp)
      OP_ADDU: C = sum;
      OP_SUBU: C = diff;
      OP_ADD: begin
        C        = sum;
        overflow = (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
      end
      OP_SUB: begin
        C        = diff;
        overflow = (A[WIDTH-1] != B[WIDTH-1]) && (diff[WIDTH-1] != A[WIDTH-1]);
      end
      OP_OR:   C = A | B;
      OP_AND:  C = A & B;
      OP_EQL:  C = WIDTH'(A == B);
      OP_LUI:  C = B << HALF;
      OP_SLT:  C = WIDTH'($signed(A) < $signed(B));
      OP_SLTU: C = WIDTH'(A < B);
      OP_MFHI: C = HI;
      OP_MFLO: C = LO;
      OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: C = '0;
      default: C = '0;
    endcase
    zero = (ALUOp == OP_EQL) ? (A == B) : (C == '0);
  end

  // Operand conditioning: signed ops work on magnitudes, signs fixed up at the end
  assign signed_op = (ALUOp == OP_MULT) || (ALUOp == OP_DIV);
  assign a_neg     = signed_op & A[WIDTH-1];
  assign b_neg     = signed_op & B[WIDTH-1];
  assign mag_a     = a_neg ? -A : A;
  assign mag_b     = b_neg ? -B : B;
  assign mul_req   = start && ((ALUOp == OP_MULT) || (ALUOp == OP_MULTU));
`ifdef ALU_DIV_EN
  assign div_req   = start && ((ALUOp == OP_DIV) || (ALUOp == OP_DIVU));
`else
  assign div_req   = 1'b0;
`endif

  // Shift-add step: multiplier in the low half is consumed LSB first
  assign mul_sum  = {1'b0, acc_q[W2-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
  assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

`ifdef ALU_DIV_EN
  // Restoring step: remainder in the high half, quotient bits shift in at the bottom
  assign div_diff = acc_q[W2-1:WIDTH-1] - {1'b0, opnd_q};
  assign div_next = div_diff[WIDTH] ? {acc_q[W2-2:0], 1'b0}
                                    : {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
`endif

  always_comb begin
    prod   = neg_lo_q ? -acc_q : acc_q;
    fix_hi = prod[W2-1:WIDTH];
    fix_lo = prod[WIDTH-1:0];
`ifdef ALU_DIV_EN
    if (op_div_q) begin
      if (div0_q) begin
        fix_hi = a_raw_q;
        fix_lo = '1;
      end else begin
        fix_hi = neg_hi_q ? -acc_q[W2-1:WIDTH] : acc_q[W2-1:WIDTH];
        fix_lo = neg_lo_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
      end
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (mul_req)      state_d = S_MUL;
        else if (div_req) state_d = S_DIV;
      end
      S_MUL, S_DIV: if (cnt_q == CNT_W'(WIDTH - 1)) state_d = S_FIX;
      S_FIX:   state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d == S_MUL) || (state_d == S_DIV) || (state_d == S_FIX);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q    <= '0;
      opnd_q   <= '0;
      neg_lo_q <= 1'b0;
      cnt_q    <= '0;
      HI       <= '0;
      LO       <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
`ifdef ALU_DIV_EN
      op_div_q <= 1'b0;
      div0_q   <= 1'b0;
      neg_hi_q <= 1'b0;
      a_raw_q  <= '0;
`endif
    end else begin
      busy <= busy_d;
      done <= done_d;
      case (state_q)
        S_IDLE: begin
          if (mul_req || div_req) begin
            acc_q    <= {{WIDTH{1'b0}}, mag_a};
            opnd_q   <= mag_b;
            neg_lo_q <= a_neg ^ b_neg;
            cnt_q    <= '0;
`ifdef ALU_DIV_EN
            op_div_q <= div_req;
            div0_q   <= (B == '0);
            neg_hi_q <= a_neg;
            a_raw_q  <= A;
`endif
          end
        end
        S_MUL: begin
          acc_q <= mul_next;
          cnt_q <= cnt_q + CNT_W'(1);
        end
`ifdef ALU_DIV_EN
        S_DIV: begin
          acc_q <= div_next;
          cnt_q <= cnt_q + CNT_W'(1);
        end
`endif
        S_FIX: begin
          HI <= fix_hi;
          LO <= fix_lo;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/alu_mdu.md
# alu_mdu

Parametrised successor of the single-cycle datapath ALU. It keeps the combinational integer operations and adds a multi-cycle multiply/divide unit with architectural HI/LO registers. Iterative shift-add multiply and restoring divide take WIDTH+1 cycles. A start/busy/done handshake lets the pipeline stall around the unit. It sits in EX, fed by the register-file/immediate mux and driven by the control unit's ALUOp.

## Interface
- WIDTH, 32: operand/result width; must be ≥ 4 and even.
- CNT_W, $clog2(WIDTH)+1: iteration counter width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset; asynchronous, active-high.
- A  in  WIDTH  operand A (rs).
- B  in  WIDTH  operand B (rt/imm).
- ALUOp  in  5  operation select (`ALUOp_*` from ctrl_encode_def.v).
- start  in  1  launch multi-cycle op in ALUOp; sampled on clk edge.
- C  out  WIDTH  combinational result.
- zero  out  1  combinational: (A==B) for EQL, else (C==0).
- overflow  out  1  combinational signed overflow for ADD/SUB; 0 otherwise.
- busy  out  1  multi-cycle op in progress.
- done  out  1  one-cycle pulse: HI/LO just updated.
- HI  out  WIDTH  high product / remainder register.
- LO  out  WIDTH  low product / quotient register.

## Operation
- Combinational ops use the existing codes ADDU, SUBU, OR, EQL, LUI, ADD, SUB. New codes are added to ctrl_encode_def.v: AND 5'b01000, SLT 5'b01001, SLTU 5'b01010, MULT 5'b10000, MULTU 5'b10001, DIV 5'b10010, DIVU 5'b10011, MFHI 5'b10100, MFLO 5'b10101.
- LUI: C = B << (WIDTH/2). SLT/SLTU: C = {0…,1} on signed/unsigned A<B.
- MFHI/MFLO: C = HI/LO current register value.
- Unknown ALUOp: C = 0.
- C, zero and overflow are fully combinational with no latches; every output is assigned on every path.
- FSM states:
  - IDLE: start & op∈{MULT,MULTU,DIV,DIVU} → MUL or DIV. Operands are latched; signed ops latch magnitudes and record result signs. The counter clears to 0.
  - MUL/DIV: one bit per cycle. Shift-add for MUL (2·WIDTH accumulator); restoring subtract-shift for DIV. The counter increments each cycle and moves to FIX after WIDTH iterations.
  - FIX: apply the sign correction and write HI/LO → DONE.
  - DONE: done=1 → IDLE.
- busy=1 in MUL, DIV and FIX; done=1 only in DONE.
- Signed divide: the quotient is negative iff the operand signs differ, and the remainder takes the dividend's sign. Truncation is toward zero.
- Divide by zero takes the same latency: LO = all ones, HI = dividend (A unmodified).
- Signed DIV of min/−1 gives LO = min, HI = 0.
- start in any non-IDLE state is ignored. start with a non-multi-cycle op is ignored by the FSM.
- HI/LO change only on the FIX→DONE edge or on reset.

## Timing
- Reset values: state IDLE, HI=0, LO=0, busy=0, done=0, counter=0. C/zero/overflow follow their inputs.
- rst asserted mid-operation aborts immediately: no done pulse and HI/LO cleared. The first edge after rst deasserts may accept a new start.
- Start is sampled at edge k, so busy=1 from k+1 through k+WIDTH+1. HI/LO are written at edge k+WIDTH+1, and busy falls at the same edge. done=1 for the cycle after edge k+WIDTH+1.
- Latency start→done is WIDTH+2 edges (34 for WIDTH=32).
- A start is accepted in the DONE cycle only after returning to IDLE, so the minimum initiation interval is WIDTH+3 cycles.
- MFHI/MFLO while busy return the old HI/LO. The control unit must stall on busy.

## Configuration
- `ALU_DIV_EN` defined: DIV/DIVU datapath, DIV state and divide-by-zero logic are compiled in.
- Undefined: DIV/DIVU starts are ignored (busy stays 0, HI/LO unchanged, no done), and C=0 for those codes. The multiplier is unaffected.

## Test plan
- WIDTH=32, MULTU A=0xFFFFFFFF B=0xFFFFFFFF, start at edge 0 → busy on edges 1–33, done in the cycle after edge 33, HI=0xFFFFFFFE, LO=0x00000001.
- MULT A=−3 B=5 → HI=0xFFFFFFFF, LO=0xFFFFFFF1. DIV A=−7 B=2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIV 0x80000000/0xFFFFFFFF → LO=0x80000000, HI=0.
- DIVU A=7 B=0 → same 34-edge latency, LO=0xFFFFFFFF, HI=7. With `ALU_DIV_EN` undefined → busy never rises and HI/LO are unchanged.
- Combinational checks:
  - ADD 0x7FFFFFFF+1 → C=0x80000000, overflow=1.
  - ADDU same operands → overflow=0.
  - EQL 5,5 → zero=1.
  - LUI B=0x1234 → C=0x12340000.
  - SLT −1,1 → C=1; SLTU −1,1 → C=0.
- Start MULT, assert rst at cycle 10 for 1 cycle → busy=0, HI=LO=0, no done pulse. A fresh MULTU 6×7 → LO=42, HI=0.
- Start MULTU 2×3, re-assert start with DIVU at cycle 5 → ignored. Final LO=6, single done pulse, MFLO during busy returns the previous LO.
